// File: rtl/union_op_exec_pipe.sv
// rtl/union_op_exec_pipe.sv - packed-union operand bank with pipelined MUL/ADD/READ and in-order result FIFO
// Optional feature macro: UNION_OP_EXEC_PARITY_EN (per-word parity, res_par and sticky par_err outputs)
module union_op_exec_pipe #(
    parameter  int OP_W        = 3,
    parameter  int CHANNELS    = 4,
    parameter  int PIPE_STAGES = 2,
    parameter  int OUT_DEPTH   = 4,
    localparam int W           = 2 * OP_W,
    localparam int CW          = $clog2(CHANNELS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [CW-1:0] cmd_chan,
    input  logic [W-1:0]  cmd_data,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [W-1:0]  res_data,
    output logic [CW-1:0] res_chan,
`ifdef UNION_OP_EXEC_PARITY_EN
    output logic          res_par,
    output logic          par_err,
`endif
    output logic [1:0]    res_op
);

    localparam int PW  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int OCW = $clog2(OUT_DEPTH + 1);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_MUL   = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    typedef struct packed {
        logic [OP_W-1:0] opa;
        logic [OP_W-1:0] opb;
    } ops_t;

    typedef union packed {
        logic [W-1:0] raw;
        ops_t         f;
    } word_u;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [CW-1:0] chan;
        logic [1:0]    op;
`ifdef UNION_OP_EXEC_PARITY_EN
        logic          par;
`endif
    } res_t;

    // Channel operand words
    word_u          words_q [CHANNELS];
    word_u          words_d [CHANNELS];
`ifdef UNION_OP_EXEC_PARITY_EN
    logic           wpar_q  [CHANNELS];
    logic           wpar_d  [CHANNELS];
    logic           par_err_q;
    logic           par_err_d;
`endif

    // Compute pipeline
    logic           pv_q [PIPE_STAGES];
    logic           pv_d [PIPE_STAGES];
    res_t           pe_q [PIPE_STAGES];
    res_t           pe_d [PIPE_STAGES];

    // Result FIFO and credit counter
    res_t           mem_q [OUT_DEPTH];
    res_t           mem_d [OUT_DEPTH];
    logic [PW-1:0]  wr_q, wr_d;
    logic [PW-1:0]  rd_q, rd_d;
    logic [OCW-1:0] cnt_q, cnt_d;
    logic [OCW-1:0] occ_q, occ_d;

    logic           accept;
    logic           is_compute;
    logic           chan_ok;
    logic           push;
    logic           pop;
    word_u          sel;
    logic [W-1:0]   ext_a;
    logic [W-1:0]   ext_b;
    res_t           new_e;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Command decode, operand select and arithmetic for the stage-1 entry
    always_comb begin
        cmd_ready  = (occ_q < OCW'(OUT_DEPTH));
        accept     = cmd_valid && cmd_ready;
        is_compute = (cmd_op != OP_WRITE);
        chan_ok    = ({1'b0, cmd_chan} < (CW + 1)'(CHANNELS));
        sel        = chan_ok ? words_q[cmd_chan] : '0;
        ext_a      = {{OP_W{1'b0}}, sel.f.opa};
        ext_b      = {{OP_W{1'b0}}, sel.f.opb};
        new_e      = '0;
        new_e.chan = cmd_chan;
        new_e.op   = cmd_op;
        case (cmd_op)
            OP_MUL:  new_e.data = ext_a * ext_b;
            OP_ADD:  new_e.data = ext_a + ext_b;
            OP_READ: new_e.data = sel.raw;
            default: new_e.data = '0;
        endcase
`ifdef UNION_OP_EXEC_PARITY_EN
        new_e.par = ^new_e.data;
`endif
        push = pv_q[PIPE_STAGES-1];
        pop  = (cnt_q != '0) && res_ready;
    end

    // Next-state of the channel words (WRITE to an in-range channel only)
    always_comb begin
        words_d = words_q;
        if (accept && (cmd_op == OP_WRITE) && chan_ok) begin
            words_d[cmd_chan] = cmd_data;
        end
`ifdef UNION_OP_EXEC_PARITY_EN
        wpar_d    = wpar_q;
        par_err_d = par_err_q;
        if (accept && (cmd_op == OP_WRITE) && chan_ok) begin
            wpar_d[cmd_chan] = ^cmd_data;
        end
        if (accept && (cmd_op == OP_READ) && chan_ok &&
            (wpar_q[cmd_chan] != ^words_q[cmd_chan].raw)) begin
            par_err_d = 1'b1;
        end
`endif
    end

    // Next-state of the compute pipeline; it never stalls because credits reserve a FIFO slot
    always_comb begin
        pv_d[0] = accept && is_compute;
        pe_d[0] = new_e;
        for (int i = 1; i < PIPE_STAGES; i++) begin
            pv_d[i] = pv_q[i-1];
            pe_d[i] = pe_q[i-1];
        end
    end

    // Next-state of the result FIFO and the outstanding-result credit count
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        occ_d = occ_q;
        if (push) begin
            mem_d[wr_q] = pe_q[PIPE_STAGES-1];
            wr_d        = ptr_inc(wr_q);
        end
        if (pop) begin
            rd_d = ptr_inc(rd_q);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
        if ((accept && is_compute) && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (pop && !(accept && is_compute)) begin
            occ_d = occ_q - 1'b1;
        end
    end

    // State registers; reset discards every in-flight and queued result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                words_q[i] <= '0;
`ifdef UNION_OP_EXEC_PARITY_EN
                wpar_q[i]  <= 1'b0;
`endif
            end
            for (int i = 0; i < PIPE_STAGES; i++) begin
                pv_q[i] <= 1'b0;
                pe_q[i] <= '0;
            end
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            occ_q <= '0;
`ifdef UNION_OP_EXEC_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            words_q <= words_d;
            pv_q    <= pv_d;
            pe_q    <= pe_d;
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            occ_q   <= occ_d;
`ifdef UNION_OP_EXEC_PARITY_EN
            wpar_q    <= wpar_d;
            par_err_q <= par_err_d;
`endif
        end
    end

    assign res_valid = (cnt_q != '0);
    assign res_data  = mem_q[rd_q].data;
    assign res_chan  = mem_q[rd_q].chan;
    assign res_op    = mem_q[rd_q].op;
`ifdef UNION_OP_EXEC_PARITY_EN
    assign res_par   = mem_q[rd_q].par;
    assign par_err   = par_err_q;
`endif

endmodule

// File: tb/tb_union_op_exec_pipe.sv
// tb/tb_union_op_exec_pipe.sv - randomized self-checking bench for union_op_exec_pipe
module tb_union_op_exec_pipe;

    localparam int OP_W        = 3;
    localparam int CHANNELS    = 4;
    localparam int PIPE_STAGES = 2;
    localparam int OUT_DEPTH   = 4;
    localparam int W           = 2 * OP_W;
    localparam int CW          = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [CW-1:0] cmd_chan;
    logic [W-1:0]  cmd_data;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  res_data;
    logic [CW-1:0] res_chan;
    logic [1:0]    res_op;
`ifdef UNION_OP_EXEC_PARITY_EN
    logic          res_par;
    logic          par_err;
`endif

    union_op_exec_pipe #(
        .OP_W(OP_W), .CHANNELS(CHANNELS), .PIPE_STAGES(PIPE_STAGES), .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_chan(cmd_chan), .cmd_data(cmd_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_chan(res_chan),
`ifdef UNION_OP_EXEC_PARITY_EN
        .res_par(res_par), .par_err(par_err),
`endif
        .res_op(res_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int chan;
        int op;
        int edge_no;
    } exp_t;

    exp_t q[$];
    int   words[CHANNELS];
    int   edge_n;
    int   total;
    int   bad;
    logic acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // Result rules straight from the op definitions on the {opa, opb} view
    function automatic int ref_res(input int op, input int w);
        int a;
        int b;
        a = w / (1 << OP_W);
        b = w % (1 << OP_W);
        case (op)
            1:       return a * b;
            2:       return a + b;
            default: return w;
        endcase
    endfunction

    // One clock cycle: drive inputs at the falling edge, check outputs, advance the model
    task automatic step(input logic v, input logic [1:0] op, input logic [CW-1:0] ch,
                        input logic [W-1:0] d, input logic rr, output logic accepted);
        logic  exp_rdy;
        logic  exp_rv;
        logic [W-1:0] ed;
        exp_t  e;
        cmd_valid = v;
        cmd_op    = op;
        cmd_chan  = ch;
        cmd_data  = d;
        res_ready = rr;
        exp_rdy = (q.size() < OUT_DEPTH);
        exp_rv  = (q.size() > 0) && (q[0].edge_no + PIPE_STAGES <= edge_n);
        check("cmd_ready", 32'(cmd_ready), 32'(exp_rdy));
        check("res_valid", 32'(res_valid), 32'(exp_rv));
`ifdef UNION_OP_EXEC_PARITY_EN
        check("par_err", 32'(par_err), 32'd0);
`endif
        if (exp_rv && rr) begin
            ed = W'(q[0].data);
            check("res_data", 32'(res_data), 32'(ed));
            check("res_chan", 32'(res_chan), 32'(q[0].chan));
            check("res_op", 32'(res_op), 32'(q[0].op));
`ifdef UNION_OP_EXEC_PARITY_EN
            check("res_par", 32'(res_par), 32'(^ed));
`endif
            void'(q.pop_front());
        end
        accepted = v && exp_rdy;
        if (accepted) begin
            if (op == 2'b00) begin
                words[int'(ch)] = int'(d);
            end else begin
                e.data    = ref_res(int'(op), words[int'(ch)]);
                e.chan    = int'(ch);
                e.op      = int'(op);
                e.edge_no = edge_n + 1;
                q.push_back(e);
            end
        end
        @(negedge clk);
        edge_n++;
        cmd_valid = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [CW-1:0] ch,
                         input logic [W-1:0] d, input logic rr);
        logic a;
        a = 1'b0;
        for (int i = 0; i < 20 && !a; i++) begin
            step(1'b1, op, ch, d, rr, a);
        end
        if (!a) check("issue_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() > 0; i++) begin
            step(1'b0, 2'b00, '0, '0, 1'b1, acc);
        end
        check("drain_empty", 32'(q.size()), 32'd0);
        step(1'b0, 2'b00, '0, '0, 1'b1, acc);
    endtask

    initial begin
        total = 0;
        bad = 0;
        edge_n = 0;
        for (int i = 0; i < CHANNELS; i++) words[i] = 0;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        cmd_chan = '0;
        cmd_data = '0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_res_chan", 32'(res_chan), 32'd0);
        check("rst_res_op", 32'(res_op), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        rst = 1'b0;

        // WRITE ch2 then MUL / ADD / READ, and write-then-compute on consecutive cycles
        issue(2'b00, 2'd2, 6'b101_011, 1'b1);
        issue(2'b01, 2'd2, 6'd0, 1'b1);
        drain();
        issue(2'b10, 2'd2, 6'd0, 1'b1);
        issue(2'b11, 2'd2, 6'd0, 1'b1);
        issue(2'b00, 2'd1, 6'b111_111, 1'b1);
        issue(2'b01, 2'd1, 6'd0, 1'b1);
        drain();

        // Backpressure: four outstanding results fill the credits
        issue(2'b00, 2'd0, 6'b010_011, 1'b1);
        issue(2'b00, 2'd3, 6'b110_101, 1'b1);
        for (int c = 0; c < 4; c++) issue(2'b01, CW'(c), 6'd0, 1'b0);
        repeat (3) step(1'b1, 2'b01, 2'd0, 6'd0, 1'b0, acc);
        issue(2'b01, 2'd0, 6'd0, 1'b1);
        drain();

        // Boundary operands and a WRITE while earlier results are in flight
        issue(2'b00, 2'd3, 6'b111_111, 1'b1);
        issue(2'b10, 2'd3, 6'd0, 1'b1);
        issue(2'b00, 2'd0, 6'b000_101, 1'b1);
        issue(2'b01, 2'd0, 6'd0, 1'b1);
        issue(2'b00, 2'd0, 6'b111_110, 1'b1);
        issue(2'b11, 2'd0, 6'd0, 1'b1);
        issue(2'b00, 2'd1, 6'b000_111, 1'b1);
        issue(2'b11, 2'd1, 6'd0, 1'b1);
        drain();

        // Reset with two results in the FIFO and two in the pipeline
        for (int c = 0; c < 4; c++) issue(2'b01, CW'(c), 6'd0, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_res_valid", 32'(res_valid), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        q.delete();
        for (int i = 0; i < CHANNELS; i++) words[i] = 0;
        @(negedge clk);
        edge_n++;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) issue(2'b11, CW'(c), 6'd0, 1'b1);
        drain();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), CW'($urandom_range(0, 3)),
                 W'($urandom_range(0, 63)), $urandom_range(0, 3) != 0, acc);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
